// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-time game sequencer.
// Optional feature macro used by the top: REACTION_BEST_TIME_EN (best-time register).
package reaction_pkg;

  localparam int STATE_W = 3;
  localparam int TIME_W  = 14;

  localparam logic [15:0]       LFSR_SEED  = 16'hACE1;
  localparam logic [TIME_W-1:0] BEST_RESET = 14'h3FFF;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 3'd0,
    ARMED = 3'd1,
    GO    = 3'd2,
    DONE  = 3'd3,
    ERROR = 3'd4
  } state_e;

  // One step of the 16-bit Fibonacci LFSR, taps 16,14,13,11.
  // Shifting a non-zero state never produces all-zero, so no lock-up guard is needed.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

endpackage

// File: rtl/reaction_ms_tick.sv
// Millisecond prescaler: counts 0..TICKS_PER_MS-1 and flags the wrap cycle.
// A clear restarts the count so the next tick lands exactly TICKS_PER_MS cycles later.
module reaction_ms_tick #(
  parameter int TICKS_PER_MS = 10000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int               CNT_W = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TICKS_PER_MS - 1);

  logic [CNT_W-1:0] r_cnt;

  // Free-running wrap counter, restarted by clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign tick = (r_cnt == LAST);

endmodule

// File: rtl/reaction_test_ctrl.sv
// Reaction-time game sequencer: button synchronisers, LFSR pre-delay, GO LED,
// millisecond reaction counter with timeout, early-press error.
// Optional feature macro: REACTION_BEST_TIME_EN keeps the lowest valid time in best_ms;
// without it best_ms is tied to BEST_RESET.
module reaction_test_ctrl
  import reaction_pkg::*;
#(
  parameter int TICKS_PER_MS = 10000,
  parameter int MIN_DELAY_MS = 1000,
  parameter int RAND_BITS    = 11,
  parameter int MAX_MS       = 9999
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_btn,
  input  logic               react_btn,
  output logic               led,
  output logic [TIME_W-1:0]  elapsed_ms,
  output logic [STATE_W-1:0] state_out,
  output logic               start_timer,
  output logic               stop_timer,
  output logic               done,
  output logic               show_error,
  output logic [TIME_W-1:0]  best_ms
);

  // Delay counter must hold at least RAND_BITS+1 / 11 bits and the largest possible delay.
  localparam int DLY_BASE_W = (RAND_BITS + 1 > 11) ? RAND_BITS + 1 : 11;
  localparam int DLY_SUM_W  = $clog2(MIN_DELAY_MS + (1 << RAND_BITS));
  localparam int DLY_W      = (DLY_SUM_W > DLY_BASE_W) ? DLY_SUM_W : DLY_BASE_W;

  localparam logic [TIME_W-1:0] MAX_T = TIME_W'(MAX_MS);

  logic r_start_s1, r_start_s2, r_start_prev;
  logic r_react_s1, r_react_s2, r_react_prev;
  logic [15:0] r_lfsr;
  state_e r_state;
  logic [DLY_W-1:0]  r_delay;
  logic [TIME_W-1:0] r_elapsed;
  logic r_led, r_start_timer, r_stop_timer, r_done, r_err;

  logic w_start_edge, w_react_edge, w_tick, w_clr;
  logic w_arm_now, w_go_now;
  logic [DLY_W-1:0] w_new_delay;

  // Two-flop synchronisers plus a history flop for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_start_s1   <= 1'b0;
      r_start_s2   <= 1'b0;
      r_start_prev <= 1'b0;
      r_react_s1   <= 1'b0;
      r_react_s2   <= 1'b0;
      r_react_prev <= 1'b0;
    end else begin
      r_start_s1   <= start_btn;
      r_start_s2   <= r_start_s1;
      r_start_prev <= r_start_s2;
      r_react_s1   <= react_btn;
      r_react_s2   <= r_react_s1;
      r_react_prev <= r_react_s2;
    end
  end

  assign w_start_edge = r_start_s2 & ~r_start_prev;
  assign w_react_edge = r_react_s2 & ~r_react_prev;

  // Pseudo-random source for the pre-GO delay, stepping every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= LFSR_SEED;
    end else begin
      r_lfsr <= lfsr_next(r_lfsr);
    end
  end

  assign w_new_delay = DLY_W'(MIN_DELAY_MS) + DLY_W'(r_lfsr[RAND_BITS-1:0]);

  // Decode the two transitions that restart the millisecond prescaler.
  // GO is entered on the tick that would take the delay to zero, so the wait is exactly delay ms.
  always_comb begin
    w_arm_now = 1'b0;
    w_go_now  = 1'b0;
    case (r_state)
      IDLE, DONE, ERROR: w_arm_now = w_start_edge;
      ARMED: w_go_now = !w_react_edge &&
                        ((r_delay == '0) || (w_tick && (r_delay == DLY_W'(1))));
      default: w_arm_now = 1'b0;
    endcase
  end

  assign w_clr = w_arm_now | w_go_now;

  reaction_ms_tick #(
    .TICKS_PER_MS (TICKS_PER_MS)
  ) u_ms_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_clr),
    .tick  (w_tick)
  );

  // Game FSM with all status outputs registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_delay       <= '0;
      r_elapsed     <= '0;
      r_led         <= 1'b0;
      r_start_timer <= 1'b0;
      r_stop_timer  <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_start_timer <= 1'b0;
      r_stop_timer  <= 1'b0;
      case (r_state)
        IDLE, DONE, ERROR: begin
          if (w_arm_now) begin
            r_state   <= ARMED;
            r_delay   <= w_new_delay;
            r_elapsed <= '0;
            r_led     <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
          end
        end
        ARMED: begin
          if (w_react_edge) begin
            r_state   <= ERROR;
            r_err     <= 1'b1;
            r_elapsed <= '0;
          end else if (w_go_now) begin
            r_state       <= GO;
            r_led         <= 1'b1;
            r_start_timer <= 1'b1;
            r_elapsed     <= '0;
          end else if (w_tick) begin
            r_delay <= r_delay - DLY_W'(1);
          end
        end
        GO: begin
          if (w_react_edge) begin
            r_state      <= DONE;
            r_led        <= 1'b0;
            r_done       <= 1'b1;
            r_stop_timer <= 1'b1;
          end else if (w_tick) begin
            if ((r_elapsed + TIME_W'(1)) >= MAX_T) begin
              r_elapsed    <= MAX_T;
              r_state      <= DONE;
              r_led        <= 1'b0;
              r_done       <= 1'b1;
              r_stop_timer <= 1'b1;
            end else begin
              r_elapsed <= r_elapsed + TIME_W'(1);
            end
          end
        end
        default: begin
          r_state   <= IDLE;
          r_delay   <= '0;
          r_elapsed <= '0;
          r_led     <= 1'b0;
          r_done    <= 1'b0;
          r_err     <= 1'b0;
        end
      endcase
    end
  end

`ifdef REACTION_BEST_TIME_EN
  logic [TIME_W-1:0] r_best;

  // Keep the lowest react-terminated time; timeouts never count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_best <= BEST_RESET;
    end else if ((r_state == GO) && w_react_edge && (r_elapsed < r_best)) begin
      r_best <= r_elapsed;
    end
  end

  assign best_ms = r_best;
`else
  assign best_ms = BEST_RESET;
`endif

  assign led         = r_led;
  assign elapsed_ms  = r_elapsed;
  assign state_out   = r_state;
  assign start_timer = r_start_timer;
  assign stop_timer  = r_stop_timer;
  assign done        = r_done;
  assign show_error  = r_err;

endmodule

// File: tb/tb_reaction_test_ctrl.sv
// Scoreboard bench for reaction_test_ctrl with small timing parameters.
module tb_reaction_test_ctrl;

  localparam int T     = 4;
  localparam int MIND  = 2;
  localparam int RB    = 2;
  localparam int MAXMS = 20;

  localparam int K_START = 0;
  localparam int K_STOP  = 1;
  localparam int K_ERR   = 2;

  typedef struct {
    int kind;
    int cyc;
    int el;
    int best;
  } ev_t;

  logic        clk, rst_n, start_btn, react_btn;
  logic        led, start_timer, stop_timer, done, show_error;
  logic [13:0] elapsed_ms, best_ms;
  logic [2:0]  state_out;

  int n_chk, n_pass;
  int cyc;
  int m_best;
  logic [15:0] m_lfsr;
  ev_t q[$];
  ev_t mon_e;
  logic prev_err;

  reaction_test_ctrl #(
    .TICKS_PER_MS (T),
    .MIN_DELAY_MS (MIND),
    .RAND_BITS    (RB),
    .MAX_MS       (MAXMS)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_btn   (start_btn),
    .react_btn   (react_btn),
    .led         (led),
    .elapsed_ms  (elapsed_ms),
    .state_out   (state_out),
    .start_timer (start_timer),
    .stop_timer  (stop_timer),
    .done        (done),
    .show_error  (show_error),
    .best_ms     (best_ms)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end else begin
      n_pass++;
    end
  endtask

  // Reference cycle count and LFSR value since the last reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc    <= 0;
      m_lfsr <= 16'hACE1;
    end else begin
      cyc    <= cyc + 1;
      m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end
  end

  // Monitor: every start/stop pulse or error rise must match the next expected event.
  always @(negedge clk) begin
    if (rst_n) begin
      if (start_timer || stop_timer || (show_error && !prev_err)) begin
        if (q.size() == 0) begin
          chk("unexpected_event", 1, 0);
        end else begin
          mon_e = q.pop_front();
          chk("event_kind", start_timer ? K_START : (stop_timer ? K_STOP : K_ERR), mon_e.kind);
          chk("event_cycle", cyc, mon_e.cyc);
          chk("event_elapsed", int'(elapsed_ms), mon_e.el);
          chk("event_led", int'(led), (mon_e.kind == K_START) ? 1 : 0);
          chk("event_state", int'(state_out),
              (mon_e.kind == K_START) ? 2 : ((mon_e.kind == K_STOP) ? 3 : 4));
          chk("event_done", int'(done), (mon_e.kind == K_STOP) ? 1 : 0);
          chk("event_best", int'(best_ms), mon_e.best);
        end
      end
      prev_err <= show_error;
    end else begin
      prev_err <= 1'b0;
    end
  end

  // One game round. cat picks when the react press lands relative to GO:
  // 0 early, 1 same cycle as expiry, 2 in GO, 3 on the timeout edge, 4 after timeout,
  // 5 one cycle before GO, 6 just after the 5th tick. abort: no react, reset mid-GO.
  task automatic run_round(input int hold_s, input int cat, input int rw, input bit abort);
    int c0, a, g, r, xr, d, v, last, end_c, lim;
    bit planned;
    ev_t e;
    c0 = cyc; planned = 1'b0; xr = 0; end_c = c0 + 1000; lim = 0;
    while (cyc < end_c && lim < 3000) begin
      if (cyc == c0 + 2) begin
        d = int'(m_lfsr[RB-1:0]);
        a = c0 + 3;
        g = a + (MIND + d) * T;
        case (cat)
          0: r = $urandom_range(a + 2, g - 1);
          1: r = g;
          2: r = $urandom_range(g + 1, g + MAXMS * T);
          3: r = g + MAXMS * T;
          4: r = $urandom_range(g + MAXMS * T + 1, g + MAXMS * T + 12);
          5: r = g - 1;
          default: r = g + 5 * T + 1;
        endcase
        if (abort) begin
          e = '{K_START, g, 0, m_best}; q.push_back(e);
          end_c = g + 2 * T;
        end else begin
          planned = 1'b1;
          xr = r - 3;
          if (r <= g) begin
            e = '{K_ERR, r, 0, m_best}; q.push_back(e);
            last = r;
          end else begin
            e = '{K_START, g, 0, m_best}; q.push_back(e);
            if (r <= g + MAXMS * T) begin
              v = (r - g - 1) / T;
`ifdef REACTION_BEST_TIME_EN
              if (v < m_best) m_best = v;
`endif
              e = '{K_STOP, r, v, m_best}; q.push_back(e);
              last = r;
            end else begin
              e = '{K_STOP, g + MAXMS * T, MAXMS, m_best}; q.push_back(e);
              last = g + MAXMS * T;
            end
          end
          end_c = last;
          if (xr + rw > end_c) end_c = xr + rw;
          if (c0 + hold_s > end_c) end_c = c0 + hold_s;
          end_c = end_c + 4;
        end
      end
      start_btn = ((cyc - c0) < hold_s);
      react_btn = planned && (cyc >= xr) && (cyc < xr + rw);
      @(negedge clk);
      lim++;
      if (cyc == c0 + 3) begin
        chk("arm_state", int'(state_out), 1);
        chk("arm_led", int'(led), 0);
        chk("arm_error_clear", int'(show_error), 0);
        chk("arm_done_clear", int'(done), 0);
        chk("arm_elapsed", int'(elapsed_ms), 0);
      end
    end
    start_btn = 1'b0;
    react_btn = 1'b0;
    chk("round_complete", (cyc >= end_c) ? 1 : 0, 1);
    chk("queue_empty", q.size(), 0);
    q.delete();
    if (abort) begin
      chk("abort_led_on", int'(led), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_led", int'(led), 0);
      chk("rst_state", int'(state_out), 0);
      chk("rst_elapsed", int'(elapsed_ms), 0);
      chk("rst_best", int'(best_ms), 'h3FFF);
      m_best = 'h3FFF;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_chk = 0; n_pass = 0; m_best = 'h3FFF;
    rst_n = 1'b0; start_btn = 1'b0; react_btn = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_state", int'(state_out), 0);
    chk("reset_led", int'(led), 0);
    chk("reset_elapsed", int'(elapsed_ms), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_error", int'(show_error), 0);
    chk("reset_start_timer", int'(start_timer), 0);
    chk("reset_stop_timer", int'(stop_timer), 0);
    chk("reset_best", int'(best_ms), 'h3FFF);
    rst_n = 1'b1;

    run_round(1, 6, 2, 1'b0);    // react after five ticks
    run_round(1, 0, 2, 1'b0);    // early press -> error
    run_round(1, 4, 2, 1'b0);    // timeout, late react ignored
    run_round(2, 1, 2, 1'b0);    // react and expiry same cycle
    run_round(1, 5, 40, 1'b0);   // react held across GO entry
    run_round(100, 2, 2, 1'b0);  // start held 100 cycles
    run_round(1, 3, 2, 1'b0);    // react on the timeout edge
    run_round(1, 2, 2, 1'b1);    // reset mid-GO
    run_round(1, 2, 2, 1'b0);
    for (int i = 0; i < 30; i++) begin
      run_round($urandom_range(1, 20), $urandom_range(0, 6), $urandom_range(1, 6), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
